// File: rtl/ram_arbiter_pkg.sv
//------------------------------------------------------------------------------
// ram_arbiter_pkg
//
// Shared types and constants for the RAM arbiter that lets instruction fetch
// (IF) and the load/store unit (MEM) share one single-port, synchronous-read
// RAM.
//
// Contents:
//   XLEN_WIDTH        default address/data width
//   STARVE_CNT_WIDTH  width of the anti-starvation counter
//   pend_e            owner of the read currently in flight
//   starve_cnt_t      anti-starvation counter type
//   next_pend()       owner of the read issued this cycle (if any)
//------------------------------------------------------------------------------
package ram_arbiter_pkg;

   localparam int XLEN_WIDTH       = 32;
   localparam int STARVE_CNT_WIDTH = 4;

   typedef enum logic [1:0] {
      PEND_NONE = 2'd0,
      PEND_IF   = 2'd1,
      PEND_MEM  = 2'd2
   } pend_e;

   typedef logic [STARVE_CNT_WIDTH-1:0] starve_cnt_t;

   // The read owner depends only on what was granted this cycle: a new read
   // may issue while the previous one is returning, so the old state never
   // matters. Stores complete in the grant cycle and leave nothing pending.
   function automatic pend_e next_pend(input logic if_gnt,
                                       input logic mem_gnt,
                                       input logic mem_we);
      pend_e nxt;
      nxt = PEND_NONE;
      if (if_gnt) begin
         nxt = PEND_IF;
      end else if (mem_gnt && !mem_we) begin
         nxt = PEND_MEM;
      end
      return nxt;
   endfunction

endpackage : ram_arbiter_pkg

// File: rtl/ram_arbiter_if.sv
//------------------------------------------------------------------------------
// ram_arbiter_if
//
// Bundles every bus signal around the RAM arbiter: the IF read port, the MEM
// load/store port and the shared RAM port.
//
// Modports:
//   slave   arbiter view (requests and RAM read data in; grants, read
//           returns, pauses and RAM controls out)
//   master  system view (requesters and the RAM)
//------------------------------------------------------------------------------
interface ram_arbiter_if
   import ram_arbiter_pkg::*;
#(
   parameter int XLEN = XLEN_WIDTH
);

   // IF read port
   logic            if_req;
   logic [XLEN-1:0] if_addr;
   logic            if_gnt;
   logic            if_rvalid;
   logic [XLEN-1:0] if_rdata;
   logic            if_pause;

   // MEM load/store port
   logic            mem_req;
   logic            mem_we;
   logic [XLEN-1:0] mem_addr;
   logic [XLEN-1:0] mem_wdata;
   logic            mem_gnt;
   logic            mem_rvalid;
   logic [XLEN-1:0] mem_rdata;
   logic            mem_pause;

   // Shared RAM port
   logic [XLEN-1:0] ram_addr;
   logic            ram_write_en;
   logic [XLEN-1:0] ram_write_data;
   logic [XLEN-1:0] ram_read_data;

   modport slave (
      input  if_req, if_addr,
      input  mem_req, mem_we, mem_addr, mem_wdata,
      input  ram_read_data,
      output if_gnt, if_rvalid, if_rdata, if_pause,
      output mem_gnt, mem_rvalid, mem_rdata, mem_pause,
      output ram_addr, ram_write_en, ram_write_data
   );

   modport master (
      output if_req, if_addr,
      output mem_req, mem_we, mem_addr, mem_wdata,
      output ram_read_data,
      input  if_gnt, if_rvalid, if_rdata, if_pause,
      input  mem_gnt, mem_rvalid, mem_rdata, mem_pause,
      input  ram_addr, ram_write_en, ram_write_data
   );

endinterface : ram_arbiter_if

// File: rtl/ram_arbiter.sv
//------------------------------------------------------------------------------
// ram_arbiter
//
// Shares one synchronous-read, single-port RAM between instruction fetch (IF)
// and the load/store unit (MEM). At most one access is granted per cycle;
// read data returns exactly one cycle after the grant. MEM has fixed
// priority, but after STARVE_LIMIT consecutive MEM grants with IF waiting,
// IF is forced a turn.
//
// Parameters:
//   XLEN          address/data width
//   STARVE_LIMIT  MEM grants tolerated while IF waits (legal range 1..15)
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-high reset
//   bus   ram_arbiter_if.slave: IF port, MEM port and shared RAM port
//------------------------------------------------------------------------------
module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int XLEN         = XLEN_WIDTH,
   parameter int STARVE_LIMIT = 4
) (
   input  logic         clk,
   input  logic         rst,
   ram_arbiter_if.slave bus
);

   localparam starve_cnt_t STARVE_LIMIT_C = starve_cnt_t'(STARVE_LIMIT);

   //---------------------------------------------------------------------------
   // State
   //---------------------------------------------------------------------------
   pend_e           pend_q,       pend_d;
   starve_cnt_t     starve_cnt_q, starve_cnt_d;
   logic [XLEN-1:0] if_hold_q,    if_hold_d;
   logic [XLEN-1:0] mem_hold_q,   mem_hold_d;

   //---------------------------------------------------------------------------
   // Combinational signals
   //---------------------------------------------------------------------------
   logic            force_if;
   logic            if_gnt;
   logic            mem_gnt;
   logic            ram_write_en;
   logic [XLEN-1:0] ram_addr;
   logic [XLEN-1:0] ram_write_data;
   logic            if_rvalid;
   logic            mem_rvalid;
   logic [XLEN-1:0] if_rdata;
   logic [XLEN-1:0] mem_rdata;

   //---------------------------------------------------------------------------
   // Grant and RAM port mux
   //---------------------------------------------------------------------------
   // Grants are combinational, so they are masked by rst to keep the RAM port
   // quiet (no stray write strobe) for the whole time reset is held.
   always_comb begin
      force_if       = (starve_cnt_q == STARVE_LIMIT_C);
      if_gnt         = 1'b0;
      mem_gnt        = 1'b0;
      ram_addr       = '0;
      ram_write_en   = 1'b0;
      ram_write_data = '0;

      if (!rst) begin
         if_gnt  = bus.if_req & (~bus.mem_req | force_if);
         mem_gnt = bus.mem_req & ~if_gnt;
      end

      if (mem_gnt) begin
         ram_addr = bus.mem_addr;
      end else if (if_gnt) begin
         ram_addr = bus.if_addr;
      end

      ram_write_en = mem_gnt & bus.mem_we;
      if (ram_write_en) begin
         ram_write_data = bus.mem_wdata;
      end
   end

   //---------------------------------------------------------------------------
   // Anti-starvation counter
   //---------------------------------------------------------------------------
   // Counts MEM grants that happened while IF was waiting. It stops at the
   // limit; the forced IF grant that follows clears it, so it never wraps.
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (!bus.if_req || if_gnt) begin
         starve_cnt_d = '0;
      end else if (mem_gnt && (starve_cnt_q != STARVE_LIMIT_C)) begin
         starve_cnt_d = starve_cnt_q + starve_cnt_t'(1);
      end
   end

   //---------------------------------------------------------------------------
   // Pending-read FSM and read return
   //---------------------------------------------------------------------------
   always_comb begin
      pend_d     = next_pend(if_gnt, mem_gnt, bus.mem_we);

      if_rvalid  = (pend_q == PEND_IF);
      mem_rvalid = (pend_q == PEND_MEM);

      // The owner sees RAM data straight through in the return cycle; the
      // holding register keeps that value visible afterwards. The other
      // requester's data is left untouched.
      if_hold_d  = if_hold_q;
      mem_hold_d = mem_hold_q;
      if_rdata   = if_hold_q;
      mem_rdata  = mem_hold_q;

      if (if_rvalid) begin
         if_hold_d = bus.ram_read_data;
         if_rdata  = bus.ram_read_data;
      end
      if (mem_rvalid) begin
         mem_hold_d = bus.ram_read_data;
         mem_rdata  = bus.ram_read_data;
      end
   end

   //---------------------------------------------------------------------------
   // Registers
   //---------------------------------------------------------------------------
   // Resetting pend_q drops any read granted just before reset, so no
   // rvalid fires for it; the requester re-issues afterwards.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_q       <= PEND_NONE;
         starve_cnt_q <= '0;
         if_hold_q    <= '0;
         mem_hold_q   <= '0;
      end else begin
         pend_q       <= pend_d;
         starve_cnt_q <= starve_cnt_d;
         if_hold_q    <= if_hold_d;
         mem_hold_q   <= mem_hold_d;
      end
   end

   //---------------------------------------------------------------------------
   // Outputs
   //---------------------------------------------------------------------------
   assign bus.if_gnt         = if_gnt;
   assign bus.if_rvalid      = if_rvalid;
   assign bus.if_rdata       = if_rdata;
   assign bus.if_pause       = bus.if_req & ~if_gnt;

   assign bus.mem_gnt        = mem_gnt;
   assign bus.mem_rvalid     = mem_rvalid;
   assign bus.mem_rdata      = mem_rdata;
   assign bus.mem_pause      = bus.mem_req & ~mem_gnt;

   assign bus.ram_addr       = ram_addr;
   assign bus.ram_write_en   = ram_write_en;
   assign bus.ram_write_data = ram_write_data;

endmodule : ram_arbiter

// File: tb/tb_ram_arbiter.sv
//------------------------------------------------------------------------------
// tb_ram_arbiter
//
// Directed bench for ram_arbiter with a behavioural synchronous-read RAM.
// Each step drives one cycle of requests with the expected grants; reads that
// are expected to be granted push their expected data (from a bench-side
// reference memory) to a scoreboard queue, which is popped and compared when
// the read returns on the following cycle.
//------------------------------------------------------------------------------
module tb_ram_arbiter;

   localparam int XLEN   = 32;
   localparam int DEPTH  = 256;

   typedef struct {
      bit          is_mem;
      logic [31:0] data;
   } sb_entry_t;

   logic clk;
   logic rst;
   bit   mem_load;

   logic [31:0] ram_mem [DEPTH];
   logic [31:0] ref_mem [DEPTH];

   sb_entry_t   sb_q[$];
   logic [31:0] last_if_data;
   logic [31:0] last_mem_data;

   int n_cmp;
   int n_err;
   int step_no;

   ram_arbiter_if #(.XLEN(XLEN)) bus ();

   ram_arbiter #(
      .XLEN         (XLEN),
      .STARVE_LIMIT (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read RAM: data for the address presented in a cycle appears
   // in the next cycle.
   always @(posedge clk) begin
      if (mem_load) begin
         for (int i = 0; i < DEPTH; i++) begin
            ram_mem[i] <= ref_mem[i];
         end
         bus.ram_read_data <= '0;
      end else begin
         if (bus.ram_write_en) begin
            ram_mem[bus.ram_addr[9:2]] <= bus.ram_write_data;
         end
         bus.ram_read_data <= ram_mem[bus.ram_addr[9:2]];
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // One cycle of stimulus. Called just after a rising edge; samples at the
   // falling edge and returns just after the next rising edge.
   task automatic step(input logic ir, input logic [31:0] ia,
                       input logic mr, input logic mw,
                       input logic [31:0] ma, input logic [31:0] md,
                       input logic eig, input logic emg, input bit rst_after);
      string     p;
      sb_entry_t e;
      logic [31:0] exp_addr;
      step_no++;
      p = $sformatf("s%0d", step_no);
      bus.if_req    = ir;
      bus.if_addr   = ia;
      bus.mem_req   = mr;
      bus.mem_we    = mw;
      bus.mem_addr  = ma;
      bus.mem_wdata = md;
      @(negedge clk);

      // Read return for whatever was granted last cycle
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         chk({p, ".if_rvalid"},  {31'd0, bus.if_rvalid},  {31'd0, ~e.is_mem});
         chk({p, ".mem_rvalid"}, {31'd0, bus.mem_rvalid}, {31'd0, e.is_mem});
         if (e.is_mem) begin
            chk({p, ".mem_rdata"}, bus.mem_rdata, e.data);
            chk({p, ".if_rdata_hold"}, bus.if_rdata, last_if_data);
            last_mem_data = e.data;
         end else begin
            chk({p, ".if_rdata"}, bus.if_rdata, e.data);
            chk({p, ".mem_rdata_hold"}, bus.mem_rdata, last_mem_data);
            last_if_data = e.data;
         end
      end else begin
         chk({p, ".if_rvalid"},  {31'd0, bus.if_rvalid},  32'd0);
         chk({p, ".mem_rvalid"}, {31'd0, bus.mem_rvalid}, 32'd0);
         chk({p, ".if_rdata_hold"},  bus.if_rdata,  last_if_data);
         chk({p, ".mem_rdata_hold"}, bus.mem_rdata, last_mem_data);
      end

      // Grants, pauses and the RAM port for this cycle
      chk({p, ".if_gnt"},    {31'd0, bus.if_gnt},    {31'd0, eig});
      chk({p, ".mem_gnt"},   {31'd0, bus.mem_gnt},   {31'd0, emg});
      chk({p, ".if_pause"},  {31'd0, bus.if_pause},  {31'd0, ir & ~eig});
      chk({p, ".mem_pause"}, {31'd0, bus.mem_pause}, {31'd0, mr & ~emg});
      exp_addr = emg ? ma : (eig ? ia : 32'd0);
      chk({p, ".ram_addr"}, bus.ram_addr, exp_addr);
      chk({p, ".ram_write_en"}, {31'd0, bus.ram_write_en}, {31'd0, emg & mw});
      chk({p, ".ram_write_data"}, bus.ram_write_data, (emg && mw) ? md : 32'd0);

      $display("step %0d: if_req=%0b if_addr=0x%08h mem_req=%0b we=%0b mem_addr=0x%08h -> if_gnt=%0b mem_gnt=%0b if_rvalid=%0b mem_rvalid=%0b",
               step_no, ir, ia, mr, mw, ma, bus.if_gnt, bus.mem_gnt, bus.if_rvalid, bus.mem_rvalid);

      if (eig) begin
         e.is_mem = 1'b0;
         e.data   = ref_mem[ia[9:2]];
         sb_q.push_back(e);
      end else if (emg && !mw) begin
         e.is_mem = 1'b1;
         e.data   = ref_mem[ma[9:2]];
         sb_q.push_back(e);
      end else if (emg && mw) begin
         ref_mem[ma[9:2]] = md;
      end

      if (rst_after) begin
         rst         = 1'b1;
         bus.if_req  = 1'b0;
         bus.mem_req = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      step_no = 0;
      last_if_data  = '0;
      last_mem_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         ref_mem[i] = 32'h1000_0000 + 32'(i * 4);
      end
      ref_mem[32'h10  >> 2] = 32'h0050_0093;
      ref_mem[32'h100 >> 2] = 32'hDEAD_BEEF;

      // Reset with IF already requesting: everything must stay idle
      rst           = 1'b1;
      mem_load      = 1'b1;
      bus.if_req    = 1'b1;
      bus.if_addr   = 32'h10;
      bus.mem_req   = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = 32'h0;
      bus.mem_wdata = 32'h0;
      @(negedge clk);
      chk("rst.if_gnt",       {31'd0, bus.if_gnt},       32'd0);
      chk("rst.mem_gnt",      {31'd0, bus.mem_gnt},      32'd0);
      chk("rst.if_rvalid",    {31'd0, bus.if_rvalid},    32'd0);
      chk("rst.mem_rvalid",   {31'd0, bus.mem_rvalid},   32'd0);
      chk("rst.ram_write_en", {31'd0, bus.ram_write_en}, 32'd0);
      chk("rst.ram_addr",     bus.ram_addr,              32'd0);
      chk("rst.if_rdata",     bus.if_rdata,              32'd0);
      chk("rst.mem_rdata",    bus.mem_rdata,             32'd0);
      @(posedge clk);
      #1;
      rst      = 1'b0;
      mem_load = 1'b0;

      // First IF fetch after reset
      step(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
      idle();

      // Back-to-back IF reads, no bubbles
      step(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
      idle();

      // Collision: MEM load wins, IF goes next cycle
      step(1'b1, 32'h40, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 32'h40, 1'b0, 1'b0, 32'h0,   32'h0, 1'b1, 1'b0, 1'b0);
      idle();

      // Starvation: four MEM grants, forced IF grant, then MEM again
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 32'h80, 1'b1, 1'b0, 32'h20 + 32'(i * 4), 32'h0, 1'b0, 1'b1, 1'b0);
      end
      step(1'b1, 32'h80, 1'b1, 1'b0, 32'h30, 32'h0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 32'h0,  1'b1, 1'b0, 32'h30, 32'h0, 1'b0, 1'b1, 1'b0);
      idle();

      // Store, then load back the stored word
      step(1'b0, 32'h0, 1'b1, 1'b1, 32'h200, 32'h1234_5678, 1'b0, 1'b1, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0,         1'b0, 1'b1, 1'b0);
      idle();

      // Reset held across the edge that would return an IF read
      step(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
      chk("mrst.if_rvalid",  {31'd0, bus.if_rvalid},  32'd0);
      chk("mrst.mem_rvalid", {31'd0, bus.mem_rvalid}, 32'd0);
      chk("mrst.if_rdata",   bus.if_rdata,            32'd0);
      chk("mrst.mem_rdata",  bus.mem_rdata,           32'd0);
      rst = 1'b0;
      sb_q.delete();
      last_if_data  = '0;
      last_mem_data = '0;
      idle();

      // Re-issue after reset
      step(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
      idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_ram_arbiter

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
Shares one synchronous-read, single-port RAM between two requesters: instruction fetch (requester IF) and the load/store unit (requester MEM). Sits between ifu/mem and ram, replacing their dedicated ports. Grants one access per cycle, returns read data one cycle after grant, and produces pause outputs so the pipeline holds stalled stages. MEM has fixed priority, with an anti-starvation counter that forces an IF turn.

Parameters:
XLEN, 32, address/data width
STARVE_LIMIT, 4, consecutive MEM grants while IF is waiting before IF is forced a grant (legal range 1..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
if_req  in  1  IF read request
if_addr  in  XLEN  IF read address
if_gnt  out  1  IF request accepted this cycle
if_rvalid  out  1  if_rdata valid this cycle
if_rdata  out  XLEN  IF read data
if_pause  out  1  if_req & ~if_gnt
mem_req  in  1  MEM request
mem_we  in  1  1 = store, 0 = load
mem_addr  in  XLEN  MEM address
mem_wdata  in  XLEN  store data
mem_gnt  out  1  MEM request accepted this cycle
mem_rvalid  out  1  mem_rdata valid this cycle (loads only)
mem_rdata  out  XLEN  MEM load data
mem_pause  out  1  mem_req & ~mem_gnt
ram_addr  out  XLEN  RAM address
ram_write_en  out  1  RAM write strobe
ram_write_data  out  XLEN  RAM write data
ram_read_data  in  XLEN  RAM read data, valid the cycle after the address is presented

Behaviour:
- Clock is clk. Reset is rst, asynchronous and active-high.
- While rst is high: gnts = 0, rvalids = 0, rdata holding registers = 0, starve_cnt = 0, pending state = PEND_NONE, ram_write_en = 0, ram_addr = 0.
- Grant is combinational, at most one per cycle:
  - force_if = (starve_cnt == STARVE_LIMIT).
  - if_gnt = if_req & (~mem_req | force_if).
  - mem_gnt = mem_req & ~if_gnt.
- RAM port mux:
  - ram_addr = mem_addr when mem_gnt; else if_addr when if_gnt; else 0.
  - ram_write_en = mem_gnt & mem_we.
  - ram_write_data = mem_wdata when ram_write_en, else 0.
- Stores complete in the grant cycle. No rvalid is raised for a store.
- Pending FSM (registered owner of the read in flight), states PEND_NONE, PEND_IF, PEND_MEM. The next state is computed every cycle, independent of the current state (fully pipelined, one read can issue while the previous one returns):
  - if_gnt → PEND_IF.
  - mem_gnt & ~mem_we → PEND_MEM.
  - otherwise → PEND_NONE.
- Read return:
  - if_rvalid = (state == PEND_IF); mem_rvalid = (state == PEND_MEM).
  - Read latency is exactly 1 cycle after the grant.
- rdata:
  - When the owner's rvalid is high, its rdata = ram_read_data (combinational pass-through) and a holding register captures it.
  - Otherwise rdata = the holding register (last returned value, 0 after reset).
  - The non-owner's rdata is unchanged.
- starve_cnt (4-bit):
  - Increment on mem_gnt & if_req.
  - Clear on if_gnt, or when if_req is low.
  - Saturates at STARVE_LIMIT; no wrap-around is possible because the forced IF grant clears it.
- Simultaneous events:
  - Both requesting with force_if = 0 → MEM wins, if_pause = 1.
  - force_if = 1 → IF wins, mem_pause = 1; next cycle MEM wins if still requesting.
- Requester rule: hold req/addr/we/wdata stable until gnt. The arbiter does not latch unaccepted requests.
- Reset mid-operation: a read granted in the cycle before rst asserts returns no rvalid. The in-flight read is dropped, and the requester re-issues after reset.
- No request: all outputs idle, state → PEND_NONE next edge.

Decomposition:
- Add to define/const.v: `PEND_NONE 2'd0, `PEND_IF 2'd1, `PEND_MEM 2'd2, `STARVE_CNT_WIDTH 4.
- Widths use the existing `XLEN_WIDTH.
- Single module, no new sub-module. The existing dff may be reused for the two holding registers and the pending-state register.

Test Plan:
- Reset/idle: rst=1 with if_req=1 → all gnt/rvalid/write_en 0 and rdata 0. After rst falls with only if_req=1, if_addr=0x10, RAM[0x10]=0x00500093 → if_gnt=1 in cycle 0; if_rvalid=1 and if_rdata=0x00500093 in cycle 1.
- Back-to-back IF reads at 0x0, 0x4, 0x8 on consecutive cycles → if_rvalid high 3 consecutive cycles, returning the data for each address in order, no bubbles.
- Collision: if_req=1 and mem_req=1 (load, 0x100, RAM=0xDEADBEEF) → mem_gnt=1, if_pause=1; next cycle mem_rvalid=1 with 0xDEADBEEF and if_gnt=1.
- Starvation: mem_req held 1 for loads plus if_req held 1, STARVE_LIMIT=4 → mem_gnt for 4 cycles, then if_gnt in cycle 5 with mem_pause=1, then mem_gnt again.
- Store: mem_req=1, mem_we=1, addr 0x200, wdata 0x12345678 → ram_write_en=1 in that cycle with the correct addr/data, mem_rvalid never asserted; a following load of 0x200 returns 0x12345678.
- Async reset mid-read: IF granted, rst pulsed before the next clock edge → if_rvalid stays 0, state is PEND_NONE, and if_rdata is 0.
